// File: rtl/pc_sched.sv
// Next-PC scheduler and fetch-stall controller for the 5-stage MIPS pipeline.
// Optional feature: define PC_ALIGN_CHK_EN to replace bad redirect targets with EXC_VEC.
module pc_sched #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
`ifdef PC_ALIGN_CHK_EN
    ,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_pc,
    input  logic        hz_stall,
    input  logic        d_redir_vld,
    input  logic [31:0] d_redir_tgt,
    input  logic        d_is_md,
    input  logic        e_md_start,
    input  logic        e_md_is_div,
    output logic [31:0] npc,
    output logic        pc_stop,
    output logic        fd_stall,
    output logic        de_flush,
    output logic        md_busy,
    output logic        redir_pend,
    output logic        exc_addr_err
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        HPEND = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_tgt;

    logic        stall;
    logic        use_redir;
    logic [31:0] redir_src;
    logic [31:0] redir_fix;

    // Busy/stall terms; reset forces every flag low.
    always_comb begin
        md_busy = !reset && (e_md_start || (cnt != CNT_W'(0)));
        stall   = !reset && (hz_stall || (d_is_md && md_busy));
    end

    assign pc_stop    = stall;
    assign fd_stall   = stall;
    assign de_flush   = stall;
    assign redir_pend = !reset && (state == HPEND);

    // A fresh D-stage redirect outranks the held one.
    assign redir_src = d_redir_vld ? d_redir_tgt : pend_tgt;
    assign use_redir = !stall && (d_redir_vld || (state == HPEND));

`ifdef PC_ALIGN_CHK_EN
    logic bad_tgt;
    assign bad_tgt      = (redir_src[1:0] != 2'b00) || (redir_src < RESET_PC);
    assign redir_fix    = bad_tgt ? EXC_VEC : redir_src;
    assign exc_addr_err = !reset && use_redir && bad_tgt;
`else
    assign redir_fix    = redir_src;
    assign exc_addr_err = 1'b0;
`endif

    always_comb begin
        npc = f_pc + 32'd4;
        if (reset)
            npc = RESET_PC;
        else if (stall)
            npc = f_pc;
        else if (use_redir)
            npc = redir_fix;
    end

    // MDU busy counter plus the redirect-hold FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= '0;
            pend_tgt <= '0;
        end else begin
            if (e_md_start)
                cnt <= e_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            else if (cnt != CNT_W'(0))
                cnt <= cnt - CNT_W'(1);

            case (state)
                RUN: begin
                    if (stall) begin
                        state <= d_redir_vld ? HPEND : HOLD;
                        if (d_redir_vld)
                            pend_tgt <= d_redir_tgt;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= RUN;
                    end else if (d_redir_vld) begin
                        state    <= HPEND;
                        pend_tgt <= d_redir_tgt;
                    end
                end
                HPEND: begin
                    if (!stall)
                        state <= RUN;
                    else if (d_redir_vld)
                        pend_tgt <= d_redir_tgt;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sched.sv
// Directed self-checking bench for pc_sched; f_pc is driven directly as the PC register would be.
module tb_pc_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        hz_stall;
    logic        d_redir_vld;
    logic [31:0] d_redir_tgt;
    logic        d_is_md;
    logic        e_md_start;
    logic        e_md_is_div;
    logic [31:0] npc;
    logic        pc_stop;
    logic        fd_stall;
    logic        de_flush;
    logic        md_busy;
    logic        redir_pend;
    logic        exc_addr_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sched dut (
        .clk          (clk),
        .reset        (reset),
        .f_pc         (f_pc),
        .hz_stall     (hz_stall),
        .d_redir_vld  (d_redir_vld),
        .d_redir_tgt  (d_redir_tgt),
        .d_is_md      (d_is_md),
        .e_md_start   (e_md_start),
        .e_md_is_div  (e_md_is_div),
        .npc          (npc),
        .pc_stop      (pc_stop),
        .fd_stall     (fd_stall),
        .de_flush     (de_flush),
        .md_busy      (md_busy),
        .redir_pend   (redir_pend),
        .exc_addr_err (exc_addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        hz_stall    = 1'b0;
        d_redir_vld = 1'b0;
        d_redir_tgt = 32'h0;
        d_is_md     = 1'b0;
        e_md_start  = 1'b0;
        e_md_is_div = 1'b0;
    endtask

    // Issue an MDU op with d_is_md held and count cycles with pc_stop high.
    task automatic md_run(input logic is_div, input int exp_cycles, input string tag);
        int stops;
        int first_free;
        stops      = 0;
        first_free = -1;
        d_is_md     = 1'b1;
        e_md_start  = 1'b1;
        e_md_is_div = is_div;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (pc_stop) stops++;
            else if (first_free < 0) first_free = i;
            tick();
            e_md_start = 1'b0;
        end
        chk({tag, "_stop_cycles"}, 32'(stops), 32'(exp_cycles));
        chk({tag, "_release_idx"}, 32'(first_free), 32'(exp_cycles));
        d_is_md = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        f_pc  = 32'h0000_1234;
        idle_inputs();
        hz_stall    = 1'b1;
        d_redir_vld = 1'b1;
        d_redir_tgt = 32'h0000_5000;
        e_md_start  = 1'b1;
        d_is_md     = 1'b1;

        // T1: reset dominates every request, for two cycles
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_npc", npc, 32'h0000_3000);
            chk("rst_pc_stop", 32'(pc_stop), 32'd0);
            chk("rst_fd_de", 32'({fd_stall, de_flush}), 32'd0);
            chk("rst_md_busy", 32'(md_busy), 32'd0);
            chk("rst_redir_pend", 32'(redir_pend), 32'd0);
            chk("rst_exc", 32'(exc_addr_err), 32'd0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        f_pc = 32'h0000_3000;
        settle();
        chk("seq_3004", npc, 32'h0000_3004);
        chk("seq_busy", 32'(md_busy), 32'd0);
        tick();
        f_pc = 32'h0000_3004;
        settle();
        chk("seq_3008", npc, 32'h0000_3008);
        tick();

        // T2: direct redirect, same-cycle effect
        f_pc        = 32'h0000_3010;
        d_redir_vld = 1'b1;
        d_redir_tgt = 32'h0000_3100;
        settle();
        chk("redir_npc", npc, 32'h0000_3100);
        chk("redir_no_stop", 32'(pc_stop), 32'd0);
        tick();
        idle_inputs();
        f_pc = 32'h0000_3100;
        settle();
        chk("redir_next", npc, 32'h0000_3104);
        tick();

        // T3: redirect arriving during a hazard stall is held
        f_pc        = 32'h0000_3104;
        hz_stall    = 1'b1;
        d_redir_vld = 1'b1;
        d_redir_tgt = 32'h0000_3200;
        settle();
        chk("hold_npc", npc, 32'h0000_3104);
        chk("hold_flags", 32'({pc_stop, fd_stall, de_flush}), 32'h7);
        chk("hold_pend_pre", 32'(redir_pend), 32'd0);
        tick();
        idle_inputs();
        settle();
        chk("pend_flag", 32'(redir_pend), 32'd1);
        chk("pend_npc", npc, 32'h0000_3200);
        chk("pend_no_stop", 32'(pc_stop), 32'd0);
        tick();
        f_pc = 32'h0000_3200;
        settle();
        chk("pend_cleared", 32'(redir_pend), 32'd0);
        chk("pend_after", npc, 32'h0000_3204);
        tick();

        // Newest held target wins
        f_pc        = 32'h0000_3204;
        hz_stall    = 1'b1;
        d_redir_vld = 1'b1;
        d_redir_tgt = 32'h0000_3300;
        tick();
        d_redir_tgt = 32'h0000_3400;
        settle();
        chk("ovr_npc_hold", npc, 32'h0000_3204);
        chk("ovr_pend", 32'(redir_pend), 32'd1);
        tick();
        idle_inputs();
        settle();
        chk("ovr_newest", npc, 32'h0000_3400);
        tick();

        // Plain hazard stall without redirect, then release
        f_pc     = 32'h0000_3400;
        hz_stall = 1'b1;
        settle();
        chk("hz_hold_npc", npc, 32'h0000_3400);
        tick();
        settle();
        chk("hz_hold_nopend", 32'(redir_pend), 32'd0);
        hz_stall = 1'b0;
        settle();
        chk("hz_release", npc, 32'h0000_3404);
        tick();

        // T4: MDU stall length
        md_run(1'b1, 11, "div");
        md_run(1'b0, 6, "mult");

        // MDU busy without a HI/LO user does not stall
        e_md_start = 1'b1;
        settle();
        chk("busy_nouse_busy", 32'(md_busy), 32'd1);
        chk("busy_nouse_stop", 32'(pc_stop), 32'd0);
        tick();
        e_md_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        settle();
        chk("mult_done_busy", 32'(md_busy), 32'd0);

        // Reissue while busy: a mult after a div reloads to 5
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        tick();
        e_md_start = 1'b0;
        tick();
        tick();
        e_md_start  = 1'b1;
        e_md_is_div = 1'b0;
        begin
            int busy_n;
            busy_n = 0;
            for (int i = 0; i < 15; i++) begin
                settle();
                if (md_busy) busy_n++;
                tick();
                e_md_start = 1'b0;
            end
            chk("reload_busy", 32'(busy_n), 32'd6);
        end

        // T5: reset during HPEND with cnt=7
        f_pc        = 32'h0000_3600;
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        tick();
        e_md_start  = 1'b0;
        hz_stall    = 1'b1;
        d_redir_vld = 1'b1;
        d_redir_tgt = 32'h0000_3500;
        tick();
        d_redir_vld = 1'b0;
        tick();
        tick();
        settle();
        chk("t5_pre_pend", 32'(redir_pend), 32'd1);
        chk("t5_pre_busy", 32'(md_busy), 32'd1);
        reset = 1'b1;
        settle();
        chk("t5_rst_npc", npc, 32'h0000_3000);
        chk("t5_rst_stop", 32'(pc_stop), 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        d_is_md = 1'b1;
        f_pc    = 32'h0000_3000;
        settle();
        chk("t5_busy", 32'(md_busy), 32'd0);
        chk("t5_stop", 32'(pc_stop), 32'd0);
        chk("t5_pend", 32'(redir_pend), 32'd0);
        chk("t5_npc", npc, 32'h0000_3004);
        tick();
        idle_inputs();

        // T6: wrap and target checking
        f_pc = 32'hFFFF_FFFC;
        settle();
        chk("wrap", npc, 32'h0000_0000);
        tick();
        f_pc        = 32'h0000_3010;
        d_redir_vld = 1'b1;
        d_redir_tgt = 32'h0000_3102;
        settle();
`ifdef PC_ALIGN_CHK_EN
        chk("misalign_npc", npc, 32'h0000_4180);
        chk("misalign_exc", 32'(exc_addr_err), 32'd1);
`else
        chk("misalign_npc", npc, 32'h0000_3102);
        chk("misalign_exc", 32'(exc_addr_err), 32'd0);
`endif
        tick();
        d_redir_tgt = 32'h0000_2000;
        settle();
`ifdef PC_ALIGN_CHK_EN
        chk("low_tgt_npc", npc, 32'h0000_4180);
`else
        chk("low_tgt_npc", npc, 32'h0000_2000);
`endif
        tick();
        idle_inputs();
        f_pc = 32'h0000_4180;
        settle();
        chk("exc_one_pulse", 32'(exc_addr_err), 32'd0);
        chk("exc_next_npc", npc, 32'h0000_4184);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
